// File: rtl/forward_mix_mac.sv
// forward_mix_mac: mix-layer compute stage, q = X*W + b over a HID_DIM x HID_DIM
// fixed-point matrix. X is latched on a valid_in strobe, W is streamed one row per
// cycle from a synchronous (1-cycle latency) weight RAM, and the rounded, saturated
// result is registered into q with a one-cycle valid pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   valid_in  one-cycle strobe, d_in valid (accepted only when idle and valid is low)
//   d_in      X matrix, element (i,k) at [(i*HID_DIM+k)*N_LEN +: N_LEN]
//   bias      per-column bias, element j at [j*N_LEN +: N_LEN]; static while busy
//   w_en      weight RAM read enable
//   w_addr    weight row index; holds its last value while w_en is low
//   w_rdata   weight row returned the cycle after w_en
//   busy      high from acceptance until the cycle valid is asserted
//   valid     one-cycle strobe, q is new
//   q         result matrix, same layout as d_in; held until the next result
module forward_mix_mac #(
    parameter int unsigned HID_DIM  = 24,
    parameter int unsigned N_LEN    = 16,
    parameter int unsigned F_LEN    = 8,
    parameter int unsigned ACC_LEN  = 2*N_LEN+8,
    parameter int unsigned ADDR_LEN = $clog2(HID_DIM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_in,
    input  logic [HID_DIM*HID_DIM*N_LEN-1:0]  d_in,
    input  logic [HID_DIM*N_LEN-1:0]          bias,
    output logic                              w_en,
    output logic [ADDR_LEN-1:0]               w_addr,
    input  logic [HID_DIM*N_LEN-1:0]          w_rdata,
    output logic                              busy,
    output logic                              valid,
    output logic [HID_DIM*HID_DIM*N_LEN-1:0]  q
);

    localparam int unsigned PROD_LEN = 2*N_LEN;
    localparam int unsigned FLAT_LEN = HID_DIM*HID_DIM*N_LEN;
    localparam logic signed [ACC_LEN-1:0] ROUND   = ACC_LEN'(1) << (F_LEN-1);
    localparam logic signed [ACC_LEN-1:0] SAT_MAX = {{(ACC_LEN-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
    localparam logic signed [ACC_LEN-1:0] SAT_MIN = {{(ACC_LEN-N_LEN+1){1'b1}}, {(N_LEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t                     state, state_nxt;
    logic [ADDR_LEN-1:0]        k, k_nxt;
    logic [ADDR_LEN-1:0]        w_addr_nxt;
    logic                       w_en_nxt, busy_nxt, valid_nxt;
    logic                       load_x, load_q;

    // acc_en/row_k: w_en and w_addr delayed to line up with the returned RAM row
    logic                       acc_en;
    logic [ADDR_LEN-1:0]        row_k;

    logic signed [N_LEN-1:0]    x_reg [HID_DIM][HID_DIM];
    logic signed [ACC_LEN-1:0]  acc   [HID_DIM][HID_DIM];
    logic signed [PROD_LEN-1:0] prod  [HID_DIM][HID_DIM];
    logic [FLAT_LEN-1:0]        q_nxt;
    logic signed [ACC_LEN-1:0]  sum_v, shr_v;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            w_en   <= 1'b0;
            w_addr <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            q      <= '0;
            acc_en <= 1'b0;
            row_k  <= '0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            w_en   <= w_en_nxt;
            w_addr <= w_addr_nxt;
            busy   <= busy_nxt;
            valid  <= valid_nxt;
            acc_en <= w_en;
            row_k  <= w_addr;
            if (load_q) begin
                q <= q_nxt;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        w_en_nxt   = 1'b0;
        w_addr_nxt = w_addr;
        busy_nxt   = busy;
        valid_nxt  = 1'b0;
        load_x     = 1'b0;
        load_q     = 1'b0;
        case (state)
            IDLE: begin
                // a strobe coinciding with the previous result's valid is dropped
                if (valid_in && !valid) begin
                    load_x     = 1'b1;
                    k_nxt      = '0;
                    w_en_nxt   = 1'b1;
                    w_addr_nxt = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (k == ADDR_LEN'(HID_DIM-1)) begin
                    state_nxt = DRAIN;
                end else begin
                    k_nxt      = k + ADDR_LEN'(1);
                    w_en_nxt   = 1'b1;
                    w_addr_nxt = k + ADDR_LEN'(1);
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                load_q    = 1'b1;
                valid_nxt = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Full-width signed products of X column row_k with the returned weight row
    always_comb begin
        for (int i = 0; i < HID_DIM; i++) begin
            for (int j = 0; j < HID_DIM; j++) begin
                prod[i][j] = PROD_LEN'(x_reg[i][row_k])
                           * PROD_LEN'($signed(w_rdata[j*N_LEN +: N_LEN]));
            end
        end
    end

    // X capture and accumulation; contents are don't-care until the first load
    always_ff @(posedge clk) begin
        if (load_x) begin
            for (int i = 0; i < HID_DIM; i++) begin
                for (int j = 0; j < HID_DIM; j++) begin
                    x_reg[i][j] <= $signed(d_in[(i*HID_DIM+j)*N_LEN +: N_LEN]);
                    acc[i][j]   <= '0;
                end
            end
        end else if (acc_en) begin
            for (int i = 0; i < HID_DIM; i++) begin
                for (int j = 0; j < HID_DIM; j++) begin
                    acc[i][j] <= acc[i][j] + ACC_LEN'(prod[i][j]);
                end
            end
        end
    end

    // Bias add, round half up, arithmetic shift and saturation
    always_comb begin
        q_nxt = '0;
        sum_v = '0;
        shr_v = '0;
        for (int i = 0; i < HID_DIM; i++) begin
            for (int j = 0; j < HID_DIM; j++) begin
                sum_v = acc[i][j]
                      + (ACC_LEN'($signed(bias[j*N_LEN +: N_LEN])) <<< F_LEN)
                      + ROUND;
                shr_v = sum_v >>> F_LEN;
                if (shr_v > SAT_MAX) begin
                    q_nxt[(i*HID_DIM+j)*N_LEN +: N_LEN] = N_LEN'(SAT_MAX);
                end else if (shr_v < SAT_MIN) begin
                    q_nxt[(i*HID_DIM+j)*N_LEN +: N_LEN] = N_LEN'(SAT_MIN);
                end else begin
                    q_nxt[(i*HID_DIM+j)*N_LEN +: N_LEN] = N_LEN'(shr_v);
                end
            end
        end
    end

endmodule
